// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and types for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned ITERS = 8;
    localparam int unsigned CNT_W = $clog2(ITERS);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    // Addend for one iteration: the multiplicand when the multiplier LSB is set.
    function automatic logic [WIDTH-1:0] partial_addend(input logic sel,
                                                        input logic [WIDTH-1:0] m);
        return sel ? m : '0;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/ready/done handshake and operand/result bus of the multiplier.
interface shift_add_multiplier_if;
    import mult_pkg::*;

    logic                start;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                ready;
    logic                busy;
    logic                done;
    logic [PROD_W-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  ready,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output ready,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/eight_bit_adder.sv
// Combinational 8-bit ripple adder with carry in and carry out.
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        sum   = total[7:0];
        cout  = total[8];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier: one add-and-shift per cycle over 8 iterations,
// using eight_bit_adder for the accumulate step.
module shift_add_multiplier
    import mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    shift_add_multiplier_if.slave bus
);

    mult_state_t        state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [PROD_W-1:0]  p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PROD_W-1:0]  product_q, product_d;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Accumulator is p[15:8]; p[0] is the multiplier bit consumed this iteration.
    always_comb begin
        add_a = p_q[PROD_W-1:WIDTH];
        add_b = partial_addend(p_q[0], m_q);
    end

    eight_bit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    p_d     = {{WIDTH{1'b0}}, bus.b};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The 9-bit adder result shifts in whole, so the carry is never lost.
                p_d   = {add_cout, add_sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    product_d = p_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        bus.ready   = (state_q == IDLE);
        bus.busy    = (state_q == RUN) || (state_q == DONE);
        bus.done    = (state_q == DONE);
        bus.product = product_q;
    end

    ready_busy_onehot: assert property (@(posedge clk) disable iff (rst)
        bus.ready ^ bus.busy);

endmodule
